// File: rtl/ca3_theta_scheduler.sv
// ca3_theta_scheduler
//   Shares one CA3 phase memory among N_REQ pattern requesters, one slot per
//   theta cycle. At each rising zero crossing of theta (armed by a dip below
//   ARM_THRESHOLD) a round-robin grant latches one requester's pattern and mode.
//   Learn+recall slots present the pattern from the peak onward; recall-only
//   slots hold it back until theta goes negative. The first falling edge of
//   mem_recalling in the trough captures the recalled pattern, which is
//   returned at the next boundary (or a timeout if no recall happened).
//
//   Optional feature: define CA3_SCHED_DECAY_SLOT_EN to force every
//   DECAY_SLOT_PERIOD-th boundary to be an idle slot, so the memory gets
//   decay time even under full load.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   clk_en              processing enable; all state moves only on it
//   theta_x             signed Q4.14 theta oscillator sample
//   req/req_mode        per-requester request level and mode (1 = learn+recall)
//   req_pattern         requester k at [k*N_UNITS +: N_UNITS]
//   gnt                 one-hot grant pulse (one clk_en cycle)
//   resp_valid/resp_id  response pulse and responding requester index
//   resp_pattern        recalled pattern (0 on timeout)
//   resp_timeout        no recall completed within the slot
//   mem_pattern_in      pattern driven into the memory
//   mem_phase_pattern   memory's recalled phase pattern
//   mem_recalling       memory's recall status
//   busy                a slot is in progress
//   debug_state         {state[2:0], armed}
module ca3_theta_scheduler #(
  parameter int WIDTH             = 18,
  parameter int N_UNITS           = 6,
  parameter int N_REQ             = 4,
  parameter int ARM_THRESHOLD     = -4096,
  parameter int DECAY_SLOT_PERIOD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic signed [WIDTH-1:0]    theta_x,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_mode,
  input  logic [N_REQ*N_UNITS-1:0]   req_pattern,
  output logic [N_REQ-1:0]           gnt,
  output logic                       resp_valid,
  output logic [2:0]                 resp_id,
  output logic [N_UNITS-1:0]         resp_pattern,
  output logic                       resp_timeout,
  output logic [N_UNITS-1:0]         mem_pattern_in,
  input  logic [N_UNITS-1:0]         mem_phase_pattern,
  input  logic                       mem_recalling,
  output logic                       busy,
  output logic [3:0]                 debug_state
);

  localparam logic signed [WIDTH-1:0] ARM_LVL    = WIDTH'(ARM_THRESHOLD);
  localparam logic signed [WIDTH-1:0] THETA_ZERO = {WIDTH{1'b0}};
  localparam logic [N_UNITS-1:0]      PAT_ZERO   = {N_UNITS{1'b0}};
  localparam logic [N_REQ-1:0]        GNT_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PEAK       = 3'd1,
    ST_PRE_TROUGH = 3'd2,
    ST_TROUGH     = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic                 armed_r, armed_s;
  logic [2:0]           rr_ptr_r, rr_ptr_s;
  logic [N_UNITS-1:0]   pat_r, pat_s;
  logic                 mode_r, mode_s;
  logic [2:0]           id_r, id_s;
  logic [N_UNITS-1:0]   cap_r, cap_s;
  logic                 rec_r, rec_s;
  logic [N_REQ-1:0]     gnt_r, gnt_s;
  logic                 resp_valid_r, resp_valid_s;
  logic [2:0]           resp_id_r, resp_id_s;
  logic [N_UNITS-1:0]   resp_pattern_r, resp_pattern_s;
  logic                 resp_timeout_r, resp_timeout_s;
  logic [N_UNITS-1:0]   mem_pattern_r, mem_pattern_s;

  logic                 boundary_s;
  logic                 theta_neg_s;
  logic                 theta_arm_s;
  logic                 decay_skip_s;
  logic                 arb_found_s;
  logic [2:0]           arb_idx_s;
  logic [N_UNITS-1:0]   arb_pat_s;
  logic                 arb_mode_s;
  int                   arb_best_s;
  int                   arb_dist_s;

  assign theta_neg_s = (theta_x < THETA_ZERO);
  assign theta_arm_s = (theta_x < ARM_LVL);
  // Rising zero crossing only counts after theta has dipped below the arm level.
  assign boundary_s  = armed_r && (theta_x > THETA_ZERO);

`ifdef CA3_SCHED_DECAY_SLOT_EN
  logic [7:0] slot_cnt_r;

  assign decay_skip_s = (slot_cnt_r == 8'(DECAY_SLOT_PERIOD - 1));

  // Slot counter: one step per theta boundary, wraps on the forced-idle slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_r <= 8'd0;
    end else if (clk_en && boundary_s) begin
      slot_cnt_r <= decay_skip_s ? 8'd0 : (slot_cnt_r + 8'd1);
    end
  end
`else
  assign decay_skip_s = 1'b0;
`endif

  // Round-robin search: pick the requester closest at or after rr_ptr.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = 3'd0;
    arb_pat_s   = PAT_ZERO;
    arb_mode_s  = 1'b0;
    arb_best_s  = N_REQ;
    arb_dist_s  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      arb_dist_s = (k + N_REQ - int'(rr_ptr_r)) % N_REQ;
      if (req[k] && (arb_dist_s < arb_best_s)) begin
        arb_best_s  = arb_dist_s;
        arb_found_s = 1'b1;
        arb_idx_s   = 3'(k);
        arb_pat_s   = req_pattern[k*N_UNITS +: N_UNITS];
        arb_mode_s  = req_mode[k];
      end else begin
        arb_best_s = arb_best_s;
      end
    end
  end

  // Next-state and next-output logic for the slot FSM.
  always_comb begin
    state_s        = state_r;
    armed_s        = armed_r;
    rr_ptr_s       = rr_ptr_r;
    pat_s          = pat_r;
    mode_s         = mode_r;
    id_s           = id_r;
    cap_s          = cap_r;
    rec_s          = rec_r;
    gnt_s          = gnt_r;
    resp_valid_s   = resp_valid_r;
    resp_id_s      = resp_id_r;
    resp_pattern_s = resp_pattern_r;
    resp_timeout_s = resp_timeout_r;
    mem_pattern_s  = mem_pattern_r;
    if (clk_en) begin
      rec_s        = mem_recalling;
      gnt_s        = {N_REQ{1'b0}};
      resp_valid_s = 1'b0;
      if (boundary_s) begin
        armed_s = 1'b0;
        // Close the running slot: captured pattern, or timeout if no recall.
        if (state_r != ST_IDLE) begin
          resp_valid_s   = 1'b1;
          resp_id_s      = id_r;
          resp_pattern_s = (state_r == ST_DONE) ? cap_r : PAT_ZERO;
          resp_timeout_s = (state_r != ST_DONE);
        end else begin
          resp_valid_s = 1'b0;
        end
        // Open the next slot on the same boundary.
        if (arb_found_s && !decay_skip_s) begin
          gnt_s    = GNT_ONE << arb_idx_s;
          id_s     = arb_idx_s;
          pat_s    = arb_pat_s;
          mode_s   = arb_mode_s;
          rr_ptr_s = 3'((int'(arb_idx_s) + 1) % N_REQ);
          state_s  = arb_mode_s ? ST_PEAK : ST_PRE_TROUGH;
        end else begin
          state_s = ST_IDLE;
        end
      end else begin
        if (theta_arm_s) begin
          armed_s = 1'b1;
        end else begin
          armed_s = armed_r;
        end
        case (state_r)
          ST_PEAK, ST_PRE_TROUGH: begin
            if (theta_neg_s) begin
              state_s = ST_TROUGH;
            end else begin
              state_s = state_r;
            end
          end
          ST_TROUGH: begin
            // Recall completes on the falling edge of mem_recalling.
            if (rec_r && !mem_recalling) begin
              cap_s   = mem_phase_pattern;
              state_s = ST_DONE;
            end else begin
              state_s = state_r;
            end
          end
          default: state_s = state_r;
        endcase
      end
      // Recall-only slots keep the input at zero until the trough.
      case (state_s)
        ST_PEAK, ST_TROUGH, ST_DONE: mem_pattern_s = pat_s;
        default:                     mem_pattern_s = PAT_ZERO;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      armed_r        <= 1'b0;
      rr_ptr_r       <= 3'd0;
      pat_r          <= PAT_ZERO;
      mode_r         <= 1'b0;
      id_r           <= 3'd0;
      cap_r          <= PAT_ZERO;
      rec_r          <= 1'b0;
      gnt_r          <= {N_REQ{1'b0}};
      resp_valid_r   <= 1'b0;
      resp_id_r      <= 3'd0;
      resp_pattern_r <= PAT_ZERO;
      resp_timeout_r <= 1'b0;
      mem_pattern_r  <= PAT_ZERO;
    end else begin
      state_r        <= state_s;
      armed_r        <= armed_s;
      rr_ptr_r       <= rr_ptr_s;
      pat_r          <= pat_s;
      mode_r         <= mode_s;
      id_r           <= id_s;
      cap_r          <= cap_s;
      rec_r          <= rec_s;
      gnt_r          <= gnt_s;
      resp_valid_r   <= resp_valid_s;
      resp_id_r      <= resp_id_s;
      resp_pattern_r <= resp_pattern_s;
      resp_timeout_r <= resp_timeout_s;
      mem_pattern_r  <= mem_pattern_s;
    end
  end

  assign gnt            = gnt_r;
  assign resp_valid     = resp_valid_r;
  assign resp_id        = resp_id_r;
  assign resp_pattern   = resp_pattern_r;
  assign resp_timeout   = resp_timeout_r;
  assign mem_pattern_in = mem_pattern_r;
  assign busy           = (state_r != ST_IDLE);
  assign debug_state    = {state_r, armed_r};

endmodule
